// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared LZ77 constants and state encoding for encoder and decoder
package lz77_pkg;
  localparam int         SEARCH_DEPTH = 10;
  localparam int         MAX_MATCH    = 5;
  localparam logic [7:0] TERM_CHAR    = 8'h24;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DONE
  } state_t;
endpackage

// File: rtl/lz77_hist_buf.sv
// rtl/lz77_hist_buf.sv - LZ77 history shift register, entry 0 is the most recent char
module lz77_hist_buf #(
  parameter int DEPTH = lz77_pkg::SEARCH_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_en,
  input  logic [7:0] shift_data,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (shift_en) begin
      mem[0] <= shift_data;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  // Indices past the buffer read as zero rather than aliasing into it.
  assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : 8'h00;
endmodule

// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 (offset, length, literal) codeword decoder, one char per cycle
module lz77_decoder #(
  parameter int SEARCH_DEPTH = lz77_pkg::SEARCH_DEPTH,
  parameter int MAX_MATCH    = lz77_pkg::MAX_MATCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] offset,
  input  logic [2:0] match_len,
  input  logic [7:0] char_in,
  output logic       out_valid,
  output logic [7:0] char_out,
  output logic       finish,
  output logic       err
);
  import lz77_pkg::*;

  state_t     state, state_nxt;
  logic [3:0] off_r;
  logic [2:0] cnt_r;
  logic [7:0] lit_r;
  logic       lit_done;
  logic       accept;
  logic       illegal;
  logic [2:0] eff_len;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;
  logic       emit;
  logic [7:0] emit_data;

  assign accept  = in_valid && (state == IDLE);
  assign illegal = ({1'b0, offset} >= 5'(SEARCH_DEPTH)) ||
                   ({1'b0, match_len} > 4'(MAX_MATCH));
  assign eff_len = illegal ? 3'd0 : match_len;
  // The first char is produced on the accept edge, so read straight from the input offset.
  assign rd_idx  = (state == IDLE) ? offset : off_r;

  assign in_ready = (state == IDLE);
  assign finish   = (state == DONE);

  lz77_hist_buf #(.DEPTH(SEARCH_DEPTH)) u_hist (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (emit),
    .shift_data (emit_data),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_data = lit_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (eff_len != 3'd0) begin
            emit      = 1'b1;
            emit_data = rd_data;
            state_nxt = COPY;
          end else if (char_in == TERM_CHAR) begin
            state_nxt = DONE;
          end else begin
            emit      = 1'b1;
            emit_data = char_in;
            state_nxt = COPY;
          end
        end
      end
      COPY: begin
        if (cnt_r != 3'd0) begin
          emit      = 1'b1;
          emit_data = rd_data;
        end else if (!lit_done) begin
          if (lit_r == TERM_CHAR) state_nxt = DONE;
          else                    emit = 1'b1;
        end else begin
          // One quiet cycle after the literal keeps in_ready low while any char is shown.
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_r     <= 4'd0;
      cnt_r     <= 3'd0;
      lit_r     <= 8'h00;
      lit_done  <= 1'b0;
      out_valid <= 1'b0;
      char_out  <= 8'h00;
      err       <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) char_out <= emit_data;
      if (accept) begin
        off_r    <= offset;
        lit_r    <= char_in;
        cnt_r    <= (eff_len != 3'd0) ? eff_len - 3'd1 : 3'd0;
        lit_done <= (eff_len == 3'd0);
        err      <= err | illegal;
      end else if (state == COPY && cnt_r != 3'd0) begin
        cnt_r <= cnt_r - 3'd1;
      end else if (state == COPY && !lit_done) begin
        lit_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lz77_decoder.sv
// tb/tb_lz77_decoder.sv - self-checking bench for lz77_decoder against a list-based LZ77 model
module tb_lz77_decoder;
  logic       clk, reset, in_valid, in_ready, out_valid, finish, err;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_in, char_out;

  int checks   = 0;
  int failures = 0;

  byte unsigned model_out[$];
  byte unsigned exp_q[$];
  byte unsigned got[$];
  logic         model_err;
  int           first_j, ready_j;
  bit           ready_bad;

  lz77_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .offset    (offset),
    .match_len (match_len),
    .char_in   (char_in),
    .out_valid (out_valid),
    .char_out  (char_out),
    .finish    (finish),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1);
  end

  function automatic string q2s(input byte unsigned q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic bit q_eq(input byte unsigned a[$], input byte unsigned b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: decoded text as a plain list; a copy reads the char `o` places back from the end.
  task automatic model_cw(input int o, input int l, input byte unsigned c);
    bit ill;
    int el, idx;
    byte unsigned ch;
    exp_q.delete();
    ill = (o >= 10) || (l > 5);
    if (ill) model_err = 1'b1;
    el = ill ? 0 : l;
    for (int k = 0; k < el; k++) begin
      idx = model_out.size() - 1 - o;
      ch  = (idx >= 0) ? model_out[idx] : 8'h00;
      exp_q.push_back(ch);
      model_out.push_back(ch);
    end
    if (c != 8'h24) begin
      exp_q.push_back(c);
      model_out.push_back(c);
    end
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    offset    = 4'd0;
    match_len = 3'd0;
    char_in   = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_out.delete();
    model_err = 1'b0;
  endtask

  task automatic send(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_wait in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1; offset = o; match_len = l; char_in = c;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    offset    = 4'($urandom);
    match_len = 3'($urandom);
    char_in   = 8'($urandom);
    got.delete(); first_j = -1; ready_j = -1; ready_bad = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (out_valid) begin
        got.push_back(char_out);
        if (first_j < 0) first_j = j;
        if (in_ready) ready_bad = 1'b1;
      end
      if (in_ready || finish) begin
        ready_j = j;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%0b exp=0", finish); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (char_out !== 8'h00) begin failures++; $display("FAIL reset_char_out got=%02h exp=00", char_out); end
  endtask

  task automatic test_literals;
    byte unsigned lits[2] = '{8'h41, 8'h42};
    foreach (lits[i]) begin
      model_cw(0, 0, lits[i]);
      send(4'd0, 3'd0, lits[i]);
      checks++; if (!q_eq(got, exp_q)) begin failures++; $display("FAIL literal_chars got=%s exp=%s", q2s(got), q2s(exp_q)); end
      checks++; if (first_j != 0) begin failures++; $display("FAIL literal_latency got=%0d exp=0", first_j); end
      checks++; if (ready_j != 1) begin failures++; $display("FAIL literal_throughput got=%0d exp=1", ready_j); end
    end
  endtask

  task automatic test_overlap;
    model_cw(1, 5, 8'h43);
    send(4'd1, 3'd5, 8'h43);
    checks++; if (!q_eq(got, exp_q)) begin failures++; $display("FAIL overlap_chars got=%s exp=%s", q2s(got), q2s(exp_q)); end
    checks++; if (ready_bad) begin failures++; $display("FAIL overlap_in_ready_low got=1 exp=0"); end
    checks++; if (ready_j != 6) begin failures++; $display("FAIL overlap_throughput got=%0d exp=6", ready_j); end
  endtask

  task automatic test_illegal;
    model_cw(12, 2, 8'h5a);
    send(4'd12, 3'd2, 8'h5a);
    checks++; if (!q_eq(got, exp_q)) begin failures++; $display("FAIL illegal_chars got=%s exp=%s", q2s(got), q2s(exp_q)); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%0b exp=1", err); end
  endtask

  task automatic test_random;
    int o, l;
    byte unsigned c;
    bit bad_chars = 0, bad_tp = 0, bad_err = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      o = $urandom_range(0, 11);
      l = $urandom_range(0, 7);
      c = 8'($urandom_range(8'h20, 8'h7e));
      if (c == 8'h24) c = 8'h25;
      model_cw(o, l, c);
      send(4'(o), 3'(l), c);
      if (!q_eq(got, exp_q)) begin
        bad_chars = 1;
        $display("FAIL random_chars cw=(%0d,%0d,%02h) got=%s exp=%s", o, l, c, q2s(got), q2s(exp_q));
      end
      if (ready_j != exp_q.size() || ready_bad) begin
        bad_tp = 1;
        $display("FAIL random_throughput cw=(%0d,%0d) got=%0d exp=%0d", o, l, ready_j, exp_q.size());
      end
      if (err !== model_err) begin
        bad_err = 1;
        $display("FAIL random_err cw=(%0d,%0d) got=%0b exp=%0b", o, l, err, model_err);
      end
    end
    checks++; if (bad_chars) failures++;
    checks++; if (bad_tp) failures++;
    checks++; if (bad_err) failures++;
  endtask

  task automatic test_term_len0;
    bit bad = 0;
    do_reset();
    model_cw(0, 0, 8'h4b);
    send(4'd0, 3'd0, 8'h4b);
    model_cw(0, 0, 8'h24);
    send(4'd0, 3'd0, 8'h24);
    checks++; if (got.size() != 0) begin failures++; $display("FAIL term0_chars got=%s exp=none", q2s(got)); end
    checks++; if (finish !== 1'b1 || ready_j != 0) begin failures++; $display("FAIL term0_finish got=%0b at=%0d exp=1 at=0", finish, ready_j); end
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; offset = 4'd0; match_len = 3'd0; char_in = 8'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || finish !== 1'b1) bad = 1;
    end
    in_valid = 1'b0;
    checks++; if (bad) begin failures++; $display("FAIL term0_sticky got=ov%0b/ir%0b/fin%0b exp=ov0/ir0/fin1", out_valid, in_ready, finish); end
  endtask

  task automatic test_term_copy;
    bit bad = 0;
    do_reset();
    model_cw(0, 0, 8'h58); send(4'd0, 3'd0, 8'h58);
    model_cw(0, 0, 8'h59); send(4'd0, 3'd0, 8'h59);
    model_cw(0, 0, 8'h5a); send(4'd0, 3'd0, 8'h5a);
    model_cw(2, 3, 8'h24);
    send(4'd2, 3'd3, 8'h24);
    checks++; if (!q_eq(got, exp_q)) begin failures++; $display("FAIL termcopy_chars got=%s exp=%s", q2s(got), q2s(exp_q)); end
    checks++; if (finish !== 1'b1) begin failures++; $display("FAIL termcopy_finish got=%0b exp=1", finish); end
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || finish !== 1'b1) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL termcopy_hold got=ov%0b/fin%0b exp=ov0/fin1", out_valid, finish); end
  endtask

  task automatic test_reset_mid_copy;
    bit bad = 0;
    do_reset();
    model_cw(0, 0, 8'h4d); send(4'd0, 3'd0, 8'h4d);
    model_cw(0, 0, 8'h4e); send(4'd0, 3'd0, 8'h4e);
    in_valid = 1'b1; offset = 4'd1; match_len = 3'd5; char_in = 8'h51;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midreset_first_char got=%0b exp=1", out_valid); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || char_out !== 8'h00) begin failures++; $display("FAIL midreset_clear got=ov%0b/%02h exp=ov0/00", out_valid, char_out); end
    checks++; if (in_ready !== 1'b1 || finish !== 1'b0) begin failures++; $display("FAIL midreset_state got=ir%0b/fin%0b exp=ir1/fin0", in_ready, finish); end
    @(negedge clk);
    reset = 1'b0;
    model_out.delete();
    model_err = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL midreset_quiet got=1 exp=0"); end
    model_cw(1, 1, 8'h52);
    send(4'd1, 3'd1, 8'h52);
    checks++; if (!q_eq(got, exp_q)) begin failures++; $display("FAIL midreset_after got=%s exp=%s", q2s(got), q2s(exp_q)); end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_overlap();
    test_illegal();
    test_random();
    test_term_len0();
    test_term_copy();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
